// File: rtl/rst_seq_gen.sv
// Reset sequencer: waits for a filtered PLL lock, applies a power-on delay, then
// releases N_CH active-low resets in order, one stagger interval apart.
module rst_seq_gen #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned DLY_CNT   = 2500000,
  parameter int unsigned STG_CNT   = 50000,
  parameter int unsigned LOCK_FILT = 16,
  parameter int unsigned HOLD_CNT  = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_pll_lock,
  input  logic            i_sw_rst,
  output logic [N_CH-1:0] o_reset_n,
  output logic            o_done,
  output logic [2:0]      o_state
);

  localparam longint unsigned CNT_MAX =
    (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);

  // Parameter sanity, fatal at elaboration
  generate
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
      $fatal(1, "rst_seq_gen: N_CH must be in 1..16");
    end
    if (DLY_CNT < 1) begin : g_bad_dly
      $fatal(1, "rst_seq_gen: DLY_CNT must be at least 1");
    end
    if (STG_CNT < 1) begin : g_bad_stg
      $fatal(1, "rst_seq_gen: STG_CNT must be at least 1");
    end
    if (LOCK_FILT < 1) begin : g_bad_filt
      $fatal(1, "rst_seq_gen: LOCK_FILT must be at least 1");
    end
    if (HOLD_CNT < 1) begin : g_bad_hold
      $fatal(1, "rst_seq_gen: HOLD_CNT must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > 64) begin : g_bad_cnt_w
      $fatal(1, "rst_seq_gen: CNT_W must be in 1..64");
    end
    if (64'(DLY_CNT) > CNT_MAX || 64'(STG_CNT) > CNT_MAX ||
        64'(LOCK_FILT) > CNT_MAX || 64'(HOLD_CNT) > CNT_MAX) begin : g_bad_range
      $fatal(1, "rst_seq_gen: CNT_W too narrow for the configured counts");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_POR_DLY   = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // Terminal values: each counter starts at 0 on state entry
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DLY_CNT - 1);
  localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STG_CNT - 1);

  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] stg_q, stg_d;
  logic [N_CH-1:0]  reset_n_q, reset_n_d;
  logic             done_q, done_d;
  logic             seq_active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= ST_ASSERT;
      hold_q    <= '0;
      filt_q    <= '0;
      dly_q     <= '0;
      stg_q     <= '0;
      reset_n_q <= '0;
      done_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      lock_s_q  <= lock_s_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      filt_q    <= filt_d;
      dly_q     <= dly_d;
      stg_q     <= stg_d;
      reset_n_q <= reset_n_d;
      done_q    <= done_d;
    end
  end

  // Counters default to zero so each one only advances inside its own state
  always_comb begin
    sync1_d    = i_pll_lock;
    lock_s_d   = sync1_q;
    state_d    = state_q;
    hold_d     = '0;
    filt_d     = '0;
    dly_d      = '0;
    stg_d      = '0;
    reset_n_d  = reset_n_q;
    done_d     = done_q;
    seq_active = 1'b0;

    unique case (state_q)
      ST_ASSERT: begin
        reset_n_d = '0;
        done_d    = 1'b0;
        if (hold_q >= HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
        end else begin
          hold_d = sat_inc(hold_q);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          if (filt_q >= FILT_LAST) begin
            state_d = ST_POR_DLY;
          end else begin
            filt_d = sat_inc(filt_q);
          end
        end
      end
      ST_POR_DLY: begin
        seq_active = 1'b1;
        if (dly_q >= DLY_LAST) begin
          reset_n_d = N_CH'(1);
          if (&reset_n_d) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          dly_d = sat_inc(dly_q);
        end
      end
      ST_RELEASE: begin
        seq_active = 1'b1;
        if (stg_q >= STG_LAST) begin
          // Thermometer shift keeps release strictly in bit order
          reset_n_d = (reset_n_q << 1) | N_CH'(1);
          if (&reset_n_d) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          stg_d = sat_inc(stg_q);
        end
      end
      ST_RUN: begin
        seq_active = 1'b1;
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    // Software reset or lock loss both collapse to a single clean ASSERT entry
    if (i_sw_rst || (seq_active && !lock_s_q)) begin
      state_d   = ST_ASSERT;
      hold_d    = '0;
      filt_d    = '0;
      dly_d     = '0;
      stg_d     = '0;
      reset_n_d = '0;
      done_d    = 1'b0;
    end
  end

  assign o_reset_n = reset_n_q;
  assign o_done    = done_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: a 3-channel and a 1-channel instance share stimulus and
// are compared every cycle against a timestamp-based model of the sequence.
module tb_rst_seq_gen;

  localparam int DLY  = 10;
  localparam int STG  = 4;
  localparam int FILT = 3;
  localparam int HOLD = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock  = 1'b0;
  logic       sw    = 1'b0;
  logic [2:0] rn3, st3, st1;
  logic [0:0] rn1;
  logic       done3, done1;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: edge count, ASSERT entry edge, POR_DLY entry edge, lock run length
  int   cyc, t_a, t_p, run;
  bit   seq, ls1, ls2;
  logic [2:0] e_rn3, e_st3, e_st1;
  logic       e_d3, e_d1, e_rn1;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .N_CH(3), .DLY_CNT(DLY), .STG_CNT(STG), .LOCK_FILT(FILT), .HOLD_CNT(HOLD), .CNT_W(8)
  ) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(lock), .i_sw_rst(sw),
    .o_reset_n(rn3), .o_done(done3), .o_state(st3)
  );

  rst_seq_gen #(
    .N_CH(1), .DLY_CNT(DLY), .STG_CNT(STG), .LOCK_FILT(FILT), .HOLD_CNT(HOLD), .CNT_W(8)
  ) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(lock), .i_sw_rst(sw),
    .o_reset_n(rn1), .o_done(done1), .o_state(st1)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; t_a = 0; t_p = 0; run = 0; seq = 0; ls1 = 0; ls2 = 0;
    end else begin
      cyc = cyc + 1;
      if (sw || (seq && !ls2)) begin
        seq = 0; t_a = cyc; run = 0;
      end else if (!seq && (cyc - 1 - t_a) >= HOLD) begin
        if (ls2) begin
          run = run + 1;
          if (run >= FILT) begin
            seq = 1; t_p = cyc; run = 0;
          end
        end else begin
          run = 0;
        end
      end
      ls2 = ls1;
      ls1 = lock;
    end
  end

  task automatic model_expect();
    int e;
    e = cyc - t_p;
    for (int k = 0; k < 3; k++) e_rn3[k] = seq && (e >= DLY + k * STG);
    e_d3  = seq && (e >= DLY + 2 * STG);
    e_rn1 = seq && (e >= DLY);
    e_d1  = e_rn1;
    if (!seq) begin
      e_st3 = ((cyc - t_a) < HOLD) ? 3'd0 : 3'd1;
      e_st1 = e_st3;
    end else begin
      e_st3 = (e < DLY) ? 3'd2 : ((e < DLY + 2 * STG) ? 3'd3 : 3'd4);
      e_st1 = (e < DLY) ? 3'd2 : 3'd4;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; sw = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rn3, done3, st3, rn1, done1, st1} !== 12'b0)
      $display("FAIL reset_values got %b_%b_%0d/%b_%b_%0d want all zero", rn3, done3, st3, rn1, done1, st1);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL reset_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    n_chk++;
    if (st3 !== 3'd1) $display("FAIL reset_wait_lock got st=%0d want 1", st3);
    else n_pass++;
  endtask

  task automatic test_nominal();
    int por = -1, r0 = -1, r1 = -1, r2 = -1, rd = -1, s0 = -1, sd = -1;
    lock = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done3) break;
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL nominal_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
      if (por < 0 && st3 == 3'd2) por = i;
      if (r0 < 0 && rn3[0]) r0 = i;
      if (r1 < 0 && rn3[1]) r1 = i;
      if (r2 < 0 && rn3[2]) r2 = i;
      if (rd < 0 && done3) rd = i;
      if (s0 < 0 && rn1[0]) s0 = i;
      if (sd < 0 && done1) sd = i;
    end
    n_chk++;
    if (done3 !== 1'b1 || st3 !== 3'd4 || rn3 !== 3'b111)
      $display("FAIL nominal_final got rn=%b done=%b st=%0d want 111 1 4", rn3, done3, st3);
    else n_pass++;
    n_chk++;
    if (r0 - por !== DLY) $display("FAIL nominal_ch0_delay got %0d want %0d", r0 - por, DLY);
    else n_pass++;
    n_chk++;
    if (r1 - r0 !== STG || r2 - r1 !== STG)
      $display("FAIL nominal_stagger got %0d,%0d want %0d", r1 - r0, r2 - r1, STG);
    else n_pass++;
    n_chk++;
    if (rd !== r2) $display("FAIL nominal_done_with_last got %0d want %0d", rd, r2);
    else n_pass++;
    n_chk++;
    if (s0 - por !== DLY || sd !== s0 || st1 !== 3'd4)
      $display("FAIL single_ch got rise=%0d done=%0d st=%0d want rise=%0d done=rise st=4",
               s0 - por, sd - por, st1, DLY);
    else n_pass++;
  endtask

  task automatic test_lock_glitch();
    int por = -1;
    logic [2:0] head = 3'b011;
    lock = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL glitch_drop t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL glitch_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
      if (por < 0 && st3 == 3'd2) por = i;
      lock = (i < 3) ? head[i] : 1'b1;
    end
    n_chk++;
    if (por !== 8) $display("FAIL glitch_por_entry got %0d want 8", por);
    else n_pass++;
    n_chk++;
    if (done3 !== 1'b1) $display("FAIL glitch_done got %b want 1", done3);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    int seen = -1;
    lock = 1'b0;
    repeat (6) @(negedge clk);
    lock = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (rn3 == 3'b011) break;
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL loss_pre t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    n_chk++;
    if (rn3 !== 3'b011) $display("FAIL loss_reach_ch1 got rn=%b want 011", rn3);
    else n_pass++;
    lock = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL loss_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
      if (seen < 0 && st3 == 3'd0 && rn3 == 3'b000 && !done3) seen = i;
    end
    n_chk++;
    if (seen !== 3) $display("FAIL loss_latency got %0d want 3", seen);
    else n_pass++;
    lock = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done3) break;
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL loss_reseq t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    n_chk++;
    if (done3 !== 1'b1) $display("FAIL loss_reseq_done got %b want 1", done3);
    else n_pass++;
  endtask

  task automatic test_sw_rst();
    int r0 = -1, rd = -1;
    logic [2:0] st_seq [4];
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL swrst_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
      if (i < 4) st_seq[i] = st3;
      if (i > 0 && r0 < 0 && rn3[0]) r0 = i;
      if (i > 0 && rd < 0 && done3) rd = i;
      sw = (i == 0);
    end
    n_chk++;
    if (st_seq[0] !== 3'd4 || st_seq[1] !== 3'd0 || st_seq[2] !== 3'd0 || st_seq[3] !== 3'd1)
      $display("FAIL swrst_assert_len got %0d,%0d,%0d,%0d want 4,0,0,1",
               st_seq[0], st_seq[1], st_seq[2], st_seq[3]);
    else n_pass++;
    n_chk++;
    if (r0 !== 16 || rd !== 24) $display("FAIL swrst_repeat_timing got ch0=%0d done=%0d want 16 24", r0, rd);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (st3 == 3'd3) break;
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL arst_pre t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    n_chk++;
    if (st3 !== 3'd3 || rn3 !== 3'b001) $display("FAIL arst_reach_release got st=%0d rn=%b want 3 001", st3, rn3);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({rn3, done3, st3, rn1, done1, st1} !== 12'b0)
      $display("FAIL arst_immediate got %b_%b_%0d/%b_%b_%0d want all zero", rn3, done3, st3, rn1, done1, st1);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (done3) break;
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL arst_restart t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
    end
    n_chk++;
    if (done3 !== 1'b1) $display("FAIL arst_restart_done got %b want 1", done3);
    else n_pass++;
  endtask

  task automatic test_random();
    int low_left = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      model_expect(); n_chk++;
      if ({rn3, done3, st3, rn1, done1, st1} !== {e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1})
        $display("FAIL random_trace t=%0t got %b_%b_%0d/%b_%b_%0d want %b_%b_%0d/%b_%b_%0d", $time,
                 rn3, done3, st3, rn1, done1, st1, e_rn3, e_d3, e_st3, e_rn1, e_d1, e_st1);
      else n_pass++;
      if (low_left > 0) begin
        low_left--;
        lock = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        low_left = int'($urandom_range(0, 3));
        lock = 1'b0;
      end else begin
        lock = 1'b1;
      end
      sw = ($urandom_range(0, 149) == 0);
    end
    sw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_lock_loss();
    test_sw_rst();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 Parameter N_CH, default 4: number of sequenced reset outputs, range 1..16.
REQ-002 Parameter DLY_CNT, default 2500000: power-on delay in i_clk cycles (50 ms at 50 MHz), at least 1.
REQ-003 Parameter STG_CNT, default 50000: stagger between consecutive channel releases in cycles, at least 1.
REQ-004 Parameter LOCK_FILT, default 16: consecutive synchronised lock-high cycles required, at least 1.
REQ-005 Parameter HOLD_CNT, default 16: minimum cycles spent in ASSERT, at least 1.
REQ-006 Parameter CNT_W, default 32: counter width; it must hold max(DLY_CNT, STG_CNT, LOCK_FILT, HOLD_CNT).
REQ-007 i_clk  input  1: the single clock; every register is clocked on its rising edge.
REQ-008 i_rst_n  input  1: asynchronous active-low reset.
REQ-009 i_pll_lock  input  1: PLL lock, asynchronous to i_clk.
REQ-010 i_sw_rst  input  1: synchronous software reset request, active high, any pulse length.
REQ-011 o_reset_n  output  N_CH: per-channel active-low resets; bit 0 releases first.
REQ-012 o_done  output  1: high while all channels are released.
REQ-013 o_state  output  3: current state, encoded ASSERT=0, WAIT_LOCK=1, POR_DLY=2, RELEASE=3, RUN=4.

Function
REQ-014 All outputs shall be driven directly from flops, with no combinational path from any input to any output.
REQ-015 i_pll_lock shall pass through a 2-flop synchroniser; the synchronised signal is lock_s, and all lock references below mean lock_s.
REQ-016 ASSERT: all o_reset_n bits low and o_done low; the block leaves for WAIT_LOCK exactly HOLD_CNT cycles after entry.
REQ-017 WAIT_LOCK: the filter counter increments on each lock_s high cycle and clears on any lock_s low cycle; the block moves to POR_DLY on the edge where the count reaches LOCK_FILT.
REQ-018 POR_DLY: if the block enters at edge T, o_reset_n[0] shall rise at edge T+DLY_CNT, and the state moves to RELEASE on that same edge.
REQ-019 RELEASE: o_reset_n[k] shall rise at edge T+DLY_CNT+k*STG_CNT for k=1..N_CH-1.
REQ-020 Once released, a bit shall stay high until the next return to ASSERT; bits shall never release out of order.
REQ-021 RUN: on the edge the last bit rises, the state moves to RUN and o_done goes high in the same edge.
REQ-022 When N_CH=1, POR_DLY shall go directly to RUN and o_done shall rise together with o_reset_n[0].
REQ-023 A lock_s low cycle in POR_DLY, RELEASE or RUN shall cause, on the next edge, the state to become ASSERT with all o_reset_n low, o_done low, and all counters reloaded.
REQ-024 An i_sw_rst high cycle in any state, including ASSERT, shall cause, on the next edge, the state to become ASSERT with the hold counter reloaded; a held i_sw_rst keeps the block in ASSERT.
REQ-025 When i_sw_rst and lock loss occur in the same cycle, the response shall be identical to a single ASSERT entry.
REQ-026 Counters shall saturate and never wrap; no counter shall advance outside its own state.
REQ-027 The parameter limits in REQ-001..REQ-006 shall be checked at elaboration, and a violation shall be a fatal error.

Reset
REQ-028 While i_rst_n is low, the block shall immediately and asynchronously force o_reset_n to all zeros, o_done=0, o_state=ASSERT, all counters to zero, and the synchroniser flops to 0.
REQ-029 On i_rst_n deassertion, the block shall start in ASSERT and follow REQ-016 from the first rising edge.
REQ-030 Assertion of i_rst_n in the middle of a sequence shall behave identically to power-up, with no partial state retained.

Verification
Scenarios 1-5 use N_CH=3, DLY_CNT=10, STG_CNT=4, LOCK_FILT=3, HOLD_CNT=2.
REQ-031 Nominal: release i_rst_n with lock held high -> ch0 rises 10 cycles after POR_DLY entry, ch1 4 cycles later, ch2 plus o_done 4 cycles after ch1, o_state ends at 4.
REQ-032 Lock glitch: lock high 2 cycles, low 1, then high -> the filter restarts, and POR_DLY is entered only after 3 consecutive lock_s high cycles.
REQ-033 Lock loss between ch1 and ch2 release -> all outputs low one cycle after lock_s falls, o_state=0; a full resequence follows once lock returns.
REQ-034 A 1-cycle i_sw_rst in RUN -> ASSERT for exactly 2 cycles, then WAIT_LOCK, then the full sequence repeats with identical timing.
REQ-035 i_rst_n pulsed low mid-RELEASE -> outputs go low without waiting for a clock edge; on release the sequence restarts from ASSERT.
REQ-036 With N_CH=1 -> o_reset_n[0] and o_done rise on the same edge, DLY_CNT cycles after POR_DLY entry.
